// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decoded ID operands, redirect/freeze,
// forwarding sources and the registered EX-side outputs.
interface id_ex_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          id_valid;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic [RW-1:0] id_dest;
    logic          id_uses_rt;
    logic [DW-1:0] id_rs_data;
    logic [DW-1:0] id_rt_data;
    logic [DW-1:0] id_imm;
    logic [4:0]    id_shamt;
    logic [3:0]    id_aluctrl;
    logic          id_alusrc;
    logic          id_regwrite;
    logic          id_memread;
    logic          id_memwrite;
    logic          id_memtoreg;
    logic          flush;
    logic          hold;
    logic          exmem_regwrite;
    logic [RW-1:0] exmem_rd;
    logic [DW-1:0] exmem_aluout;
    logic          memwb_regwrite;
    logic [RW-1:0] memwb_rd;
    logic [DW-1:0] memwb_data;
    logic          stall;
    logic          ex_valid;
    logic [DW-1:0] ex_in1;
    logic [DW-1:0] ex_in2;
    logic [3:0]    ex_aluctrl;
    logic [4:0]    ex_sll;
    logic [DW-1:0] ex_store_data;
    logic [RW-1:0] ex_dest;
    logic          ex_regwrite;
    logic          ex_memread;
    logic          ex_memwrite;
    logic          ex_memtoreg;

    modport master (
        output id_valid, id_rs, id_rt, id_dest, id_uses_rt,
        output id_rs_data, id_rt_data, id_imm, id_shamt,
        output id_aluctrl, id_alusrc, id_regwrite, id_memread,
        output id_memwrite, id_memtoreg, flush, hold,
        output exmem_regwrite, exmem_rd, exmem_aluout,
        output memwb_regwrite, memwb_rd, memwb_data,
        input  stall, ex_valid, ex_in1, ex_in2, ex_aluctrl,
        input  ex_sll, ex_store_data, ex_dest, ex_regwrite,
        input  ex_memread, ex_memwrite, ex_memtoreg
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_dest, id_uses_rt,
        input  id_rs_data, id_rt_data, id_imm, id_shamt,
        input  id_aluctrl, id_alusrc, id_regwrite, id_memread,
        input  id_memwrite, id_memtoreg, flush, hold,
        input  exmem_regwrite, exmem_rd, exmem_aluout,
        input  memwb_regwrite, memwb_rd, memwb_data,
        output stall, ex_valid, ex_in1, ex_in2, ex_aluctrl,
        output ex_sll, ex_store_data, ex_dest, ex_regwrite,
        output ex_memread, ex_memwrite, ex_memtoreg
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand
// forwarding and load-use bubble insertion ahead of the ALU.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] dest;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
        logic [4:0]    shamt;
        logic [3:0]    aluctrl;
        logic          alusrc;
        logic          regwrite;
        logic          memread;
        logic          memwrite;
        logic          memtoreg;
    } ex_reg_t;

    ex_reg_t ex_d;
    ex_reg_t ex_q;

    logic          hazard;
    logic          stall;
    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;

    // EX/MEM wins over MEM/WB; r0 is hardwired and never forwarded.
    function automatic logic [DW-1:0] fwd(
        input logic [RW-1:0] idx,
        input logic [DW-1:0] rf
    );
        logic [DW-1:0] r;
        r = rf;
        if (bus.exmem_regwrite && bus.exmem_rd != '0 &&
            bus.exmem_rd == idx) begin
            r = bus.exmem_aluout;
        end else if (bus.memwb_regwrite && bus.memwb_rd != '0 &&
                     bus.memwb_rd == idx) begin
            r = bus.memwb_data;
        end
        return r;
    endfunction

    always_comb begin
        hazard = ex_q.valid & ex_q.memread & (ex_q.dest != '0) &
                 bus.id_valid &
                 ((ex_q.dest == bus.id_rs) |
                  (bus.id_uses_rt & (ex_q.dest == bus.id_rt)));
        stall = hazard & ~bus.flush & ~bus.hold;
    end

    always_comb begin
        ex_d = ex_q;
        if (bus.hold) begin
            ex_d = ex_q;
        end else if (bus.flush || stall) begin
            ex_d = '0;
        end else begin
            ex_d.valid    = bus.id_valid;
            ex_d.rs       = bus.id_rs;
            ex_d.rt       = bus.id_rt;
            ex_d.dest     = bus.id_dest;
            ex_d.rs_data  = bus.id_rs_data;
            ex_d.rt_data  = bus.id_rt_data;
            ex_d.imm      = bus.id_imm;
            ex_d.shamt    = bus.id_shamt;
            ex_d.aluctrl  = bus.id_aluctrl;
            ex_d.alusrc   = bus.id_alusrc;
            ex_d.regwrite = bus.id_regwrite & bus.id_valid;
            ex_d.memread  = bus.id_memread & bus.id_valid;
            ex_d.memwrite = bus.id_memwrite & bus.id_valid;
            ex_d.memtoreg = bus.id_memtoreg & bus.id_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    always_comb begin
        fwd_rs = fwd(ex_q.rs, ex_q.rs_data);
        fwd_rt = fwd(ex_q.rt, ex_q.rt_data);
    end

    assign bus.stall         = stall;
    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_in1        = fwd_rs;
    assign bus.ex_in2        = ex_q.alusrc ? ex_q.imm : fwd_rt;
    assign bus.ex_store_data = fwd_rt;
    assign bus.ex_aluctrl    = ex_q.aluctrl;
    assign bus.ex_sll        = ex_q.shamt;
    assign bus.ex_dest       = ex_q.dest;
    assign bus.ex_regwrite   = ex_q.regwrite;
    assign bus.ex_memread    = ex_q.memread;
    assign bus.ex_memwrite   = ex_q.memwrite;
    assign bus.ex_memtoreg   = ex_q.memtoreg;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX contents are queued
// when an instruction is driven and checked after the capturing edge.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst;
    int tests = 0;
    int fails = 0;

    id_ex_stage_if #(.DW(32), .RW(5)) bus ();

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] store;
        logic [3:0]  aluctrl;
        logic [4:0]  sll;
        logic [4:0]  dest;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        mt;
    } exp_t;

    exp_t sb[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(logic v, logic [31:0] i1, logic [31:0] i2,
                        logic [31:0] st, logic [3:0] ac,
                        logic [4:0] sh, logic [4:0] d, logic rw,
                        logic mr, logic mw, logic mt);
        exp_t e;
        e.valid = v; e.in1 = i1; e.in2 = i2; e.store = st;
        e.aluctrl = ac; e.sll = sh; e.dest = d; e.rw = rw;
        e.mr = mr; e.mw = mw; e.mt = mt;
        sb.push_back(e);
    endtask

    task automatic bubble();
        push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_ex(string tag);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL %s: scoreboard empty got 0 expected 1", tag);
            return;
        end
        tests--;
        e = sb.pop_front();
        chk({tag, ".valid"}, 32'(bus.ex_valid), 32'(e.valid));
        chk({tag, ".in1"}, bus.ex_in1, e.in1);
        chk({tag, ".in2"}, bus.ex_in2, e.in2);
        chk({tag, ".store"}, bus.ex_store_data, e.store);
        chk({tag, ".aluctrl"}, 32'(bus.ex_aluctrl), 32'(e.aluctrl));
        chk({tag, ".sll"}, 32'(bus.ex_sll), 32'(e.sll));
        chk({tag, ".dest"}, 32'(bus.ex_dest), 32'(e.dest));
        chk({tag, ".rw"}, 32'(bus.ex_regwrite), 32'(e.rw));
        chk({tag, ".mr"}, 32'(bus.ex_memread), 32'(e.mr));
        chk({tag, ".mw"}, 32'(bus.ex_memwrite), 32'(e.mw));
        chk({tag, ".mt"}, 32'(bus.ex_memtoreg), 32'(e.mt));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id(logic v, logic [4:0] rs, logic [31:0] rsd,
                      logic [4:0] rt, logic [31:0] rtd, logic ur,
                      logic [4:0] d, logic [3:0] ac, logic as,
                      logic [31:0] imm, logic [4:0] sh, logic rw,
                      logic mr, logic mt);
        bus.id_valid = v; bus.id_rs = rs; bus.id_rs_data = rsd;
        bus.id_rt = rt; bus.id_rt_data = rtd; bus.id_uses_rt = ur;
        bus.id_dest = d; bus.id_aluctrl = ac; bus.id_alusrc = as;
        bus.id_imm = imm; bus.id_shamt = sh; bus.id_regwrite = rw;
        bus.id_memread = mr; bus.id_memwrite = 1'b0;
        bus.id_memtoreg = mt;
    endtask

    task automatic fwd_off();
        bus.exmem_regwrite = 0; bus.exmem_rd = 0;
        bus.exmem_aluout = 0;
        bus.memwb_regwrite = 0; bus.memwb_rd = 0;
        bus.memwb_data = 0;
    endtask

    initial begin
        rst = 1'b1;
        bus.flush = 0;
        bus.hold = 0;
        fwd_off();
        bus.id_valid = 1; bus.id_rs = 5'($urandom);
        bus.id_rt = 5'($urandom); bus.id_dest = 5'($urandom);
        bus.id_uses_rt = 1; bus.id_rs_data = $urandom;
        bus.id_rt_data = $urandom; bus.id_imm = $urandom;
        bus.id_shamt = 5'($urandom); bus.id_aluctrl = 4'($urandom);
        bus.id_alusrc = 0; bus.id_regwrite = 1;
        bus.id_memread = 1; bus.id_memwrite = 1;
        bus.id_memtoreg = 1;
        bubble();
        bubble();
        tick();
        check_ex("rst1");
        tick();
        check_ex("rst2");
        chk("rst.stall", 32'(bus.stall), 0);

        rst = 1'b0;
        id(1, 8, 5, 9, 7, 1, 3, 2, 0, 0, 0, 1, 0, 0);
        push(1, 5, 7, 7, 2, 0, 3, 1, 0, 0, 0);
        tick();
        check_ex("add");

        bus.hold = 1;
        bus.exmem_regwrite = 1; bus.exmem_rd = 8;
        bus.exmem_aluout = 32'h11;
        bus.memwb_regwrite = 1; bus.memwb_rd = 8;
        bus.memwb_data = 32'h22;
        #1;
        chk("fwd.exmem", bus.ex_in1, 32'h11);
        bus.exmem_regwrite = 0;
        #1;
        chk("fwd.memwb", bus.ex_in1, 32'h22);
        tick();
        chk("hold.in1", bus.ex_in1, 32'h22);
        chk("hold.valid", 32'(bus.ex_valid), 1);

        bus.hold = 0;
        bus.exmem_regwrite = 1; bus.exmem_rd = 0;
        bus.memwb_regwrite = 1; bus.memwb_rd = 0;
        id(1, 0, 32'h44, 9, 7, 1, 3, 2, 0, 0, 0, 1, 0, 0);
        push(1, 32'h44, 7, 7, 2, 0, 3, 1, 0, 0, 0);
        tick();
        check_ex("r0");
        fwd_off();

        id(0, 3, 32'h55, 4, 32'h66, 1, 7, 2, 0, 0, 0, 1, 1, 1);
        push(0, 32'h55, 32'h66, 32'h66, 2, 0, 7, 0, 0, 0, 0);
        tick();
        check_ex("novalid");

        id(1, 1, 32'h100, 2, 9, 0, 10, 2, 1, 4, 0, 1, 1, 1);
        push(1, 32'h100, 4, 9, 2, 0, 10, 1, 1, 0, 1);
        tick();
        check_ex("lw");
        id(1, 10, 1, 11, 2, 1, 12, 2, 0, 0, 0, 1, 0, 0);
        #1;
        chk("lu.stall", 32'(bus.stall), 1);
        bubble();
        tick();
        check_ex("lu.bubble");
        chk("lu.release", 32'(bus.stall), 0);

        id(1, 1, 32'h100, 2, 9, 0, 10, 2, 1, 4, 0, 1, 1, 1);
        push(1, 32'h100, 4, 9, 2, 0, 10, 1, 1, 0, 1);
        tick();
        check_ex("lw2");
        id(1, 5, 1, 10, 2, 0, 12, 2, 1, 0, 0, 1, 0, 0);
        #1;
        chk("lu.nort", 32'(bus.stall), 0);
        bus.id_uses_rt = 1;
        #1;
        chk("lu.rt", 32'(bus.stall), 1);
        bus.flush = 1;
        #1;
        chk("lu.flush", 32'(bus.stall), 0);
        bubble();
        tick();
        check_ex("flush");
        bus.flush = 0;

        id(1, 12, 32'hA, 13, 32'hB, 0, 10, 2, 1, 8, 0, 1, 1, 1);
        push(1, 32'hA, 8, 32'hB, 2, 0, 10, 1, 1, 0, 1);
        tick();
        check_ex("lw3");
        bus.hold = 1; bus.flush = 1;
        id(1, 10, 1, 2, 3, 1, 20, 6, 0, 0, 0, 1, 0, 0);
        #1;
        chk("hf.stall", 32'(bus.stall), 0);
        push(1, 32'hA, 8, 32'hB, 2, 0, 10, 1, 1, 0, 1);
        tick();
        check_ex("hf.keep");
        bus.hold = 0; bus.flush = 0;

        id(1, 15, 32'h2, 14, 32'h1, 1, 5, 2, 1,
           32'hFFFFFFFC, 0, 1, 0, 0);
        push(1, 32'h2, 32'hFFFFFFFC, 32'h33, 2, 0, 5, 1, 0, 0, 0);
        tick();
        bus.exmem_regwrite = 1; bus.exmem_rd = 14;
        bus.exmem_aluout = 32'h33;
        #1;
        check_ex("imm");
        fwd_off();

        id(1, 0, 32'h99, 16, 32'h3, 1, 6, 15, 0, 0, 4, 1, 0, 0);
        push(1, 32'h99, 32'h3, 32'h3, 15, 4, 6, 1, 0, 0, 0);
        tick();
        check_ex("sll");

        id(1, 1, 32'h100, 2, 9, 0, 10, 2, 1, 4, 0, 1, 1, 1);
        push(1, 32'h100, 4, 9, 2, 0, 10, 1, 1, 0, 1);
        tick();
        check_ex("lw4");
        id(1, 10, 1, 11, 2, 1, 12, 2, 0, 0, 0, 1, 0, 0);
        #1;
        chk("rs.stall", 32'(bus.stall), 1);
        rst = 1;
        bubble();
        tick();
        rst = 0;
        #1;
        check_ex("rs.bubble");
        chk("rs.drop", 32'(bus.stall), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage of the pipelined MIPS core; sits directly upstream of the ALU.
- Captures decoded operands and control once per cycle and resolves EX/MEM and MEM/WB forwarding.
- Detects load-use hazards and inserts bubbles.
- Drives the ALU's in1, in2, aluctrl and sll inputs.

Parameters:
- DW, 32, datapath width
- RW, 5, register-index width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt, id_dest  in  RW  source indices; resolved destination index (regdst already applied)
- id_uses_rt  in  1  instruction reads rt (R-type, store, branch)
- id_rs_data, id_rt_data  in  DW  register-file read data
- id_imm  in  DW  sign/zero-extended immediate
- id_shamt  in  5  shift amount
- id_aluctrl  in  4  ALU op: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 15 SLL
- id_alusrc  in  1  1 = in2 takes immediate
- id_regwrite, id_memread, id_memwrite, id_memtoreg  in  1  control bits
- flush  in  1  squash the instruction entering EX (branch/jump redirect)
- hold  in  1  downstream freeze; register keeps contents
- exmem_regwrite  in  1; exmem_rd  in  RW; exmem_aluout  in  DW  EX/MEM forwarding source
- memwb_regwrite  in  1; memwb_rd  in  RW; memwb_data  in  DW  MEM/WB forwarding source
- stall  out  1  load-use stall request to PC and IF/ID (combinational)
- ex_valid  out  1  EX instruction is real
- ex_in1, ex_in2  out  DW  ALU operands
- ex_aluctrl  out  4; ex_sll  out  5  ALU control and shift amount
- ex_store_data  out  DW  forwarded rt value for stores
- ex_dest  out  RW  destination index
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  1  registered control bits

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high on rst.
- Reset: all registered fields are 0, so ex_valid=0, all controls 0, ex_aluctrl=0, ex_dest=0 and all data 0. ex_in1, ex_in2 and ex_store_data read 0 unless forwarding matches with rd≠0.
- Latency: 1 cycle from the ID inputs to the registered EX fields.
- Register update priority each edge: rst > hold > flush > stall > load.
  - hold: all fields keep their values.
  - flush or stall: load a bubble. valid, regwrite, memread, memwrite, memtoreg and dest are 0; aluctrl=0; data fields are don't-care but held at 0.
  - load: capture all id_* inputs. Control bits are ANDed with id_valid.
- Load-use stall (combinational):
  - stall = ex_valid & ex_memread & (ex_dest≠0) & id_valid & ((ex_dest==id_rs) | (id_uses_rt & ex_dest==id_rt)).
  - stall is forced to 0 while flush=1 or hold=1.
- Forwarding (combinational on registered rs/rt indices and data), per operand:
  - If exmem_regwrite and exmem_rd≠0 and exmem_rd==index: use exmem_aluout.
  - Else if memwb_regwrite and memwb_rd≠0 and memwb_rd==index: use memwb_data.
  - Else use the registered register-file value.
  - EX/MEM has priority over MEM/WB when both match.
  - Register 0 is never forwarded.
- Operand outputs:
  - ex_in1 = forwarded rs.
  - ex_in2 = ex_alusrc ? ex_imm : forwarded rt.
  - ex_store_data = forwarded rt, independent of alusrc.
  - ex_sll = registered shamt.
- Forwarding outputs update the same cycle the forwarding sources change, including during hold.
- A same-cycle register-file write and read is handled inside the register file, not here.
- Reset mid-stall: the next edge produces a bubble and stall drops to 0.

Test Plan:
- Reset: rst=1 for 2 cycles with random id_* inputs -> ex_valid=0, all controls 0, ex_in1=ex_in2=0, stall=0.
- Plain load: ADD with rs=8 (data 5), rt=9 (data 7), aluctrl=2, no forwarding matches -> next cycle ex_in1=5, ex_in2=7, ex_aluctrl=2, ex_regwrite=1.
- Double forward: EX rs=8; exmem_rd=8 with aluout 0x11; memwb_rd=8 with data 0x22 -> ex_in1=0x11. Drop exmem_regwrite -> ex_in1=0x22. Set rs=0 with both sources rd=0 -> ex_in1 = registered data.
- Load-use: LW dest=10 in EX, ID holds ADD with rs=10 -> stall=1, next edge ex_valid=0. Same case with id_uses_rt=0 and rt=10, rs≠10 -> stall=0.
- Flush/hold priority: flush=1 with a valid ID instruction -> bubble. Then hold=1 with flush=1 -> register keeps the prior contents and stall=0.
- Immediate and shift: alusrc=1, imm=0xFFFFFFFC, rt forwarded to 0x33 -> ex_in2=0xFFFFFFFC, ex_store_data=0x33. Shift with aluctrl=15, shamt=4 -> ex_sll=4.
